// File: rtl/cr16_pkg.sv
// cr16_pkg: shared CR16 sequencer types, opcode/condition constants and flag bit positions.
package cr16_pkg;

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_UPDATE} state_t;

    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_JEXT   = 4'h4;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] EXT_JAL   = 4'h8;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // I_FLAGS = {N, Z, F, L, C}
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_ctrl(input logic [15:0] w);
        return w[15:12] == OP_BCOND ||
               (w[15:12] == OP_JEXT && (w[7:4] == EXT_JCOND || w[7:4] == EXT_JAL));
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational CR16 condition-code evaluation against {N, Z, F, L, C}.
module cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] I_COND,
    input  logic [4:0] I_FLAGS,
    output logic       O_TAKEN
);

    logic [15:0] t;

    always_comb begin
        t        = '0;
        t[CC_EQ] = I_FLAGS[FLAG_Z];
        t[CC_NE] = !I_FLAGS[FLAG_Z];
        t[CC_CS] = I_FLAGS[FLAG_C];
        t[CC_CC] = !I_FLAGS[FLAG_C];
        t[CC_HI] = I_FLAGS[FLAG_L];
        t[CC_LS] = !I_FLAGS[FLAG_L];
        t[CC_GT] = I_FLAGS[FLAG_N];
        t[CC_LE] = !I_FLAGS[FLAG_N];
        t[CC_FS] = I_FLAGS[FLAG_F];
        t[CC_FC] = !I_FLAGS[FLAG_F];
        t[CC_LO] = !I_FLAGS[FLAG_L] && !I_FLAGS[FLAG_Z];
        t[CC_HS] = I_FLAGS[FLAG_L] || I_FLAGS[FLAG_Z];
        t[CC_LT] = !I_FLAGS[FLAG_N] && !I_FLAGS[FLAG_Z];
        t[CC_GE] = I_FLAGS[FLAG_N] || I_FLAGS[FLAG_Z];
        t[CC_UC] = 1'b1;
        t[CC_NV] = 1'b0;
    end

    assign O_TAKEN = t[I_COND];

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: CR16 fetch/decode/update sequencer driving the program counter.
// Optional taken-branch counter enabled by defining PC_CTRL_TAKEN_COUNT_EN.
module pc_ctrl
    import cr16_pkg::*;
#(
    parameter int P_ADDRESS_WIDTH = 16,
    parameter int P_DATA_WIDTH    = 16
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic [P_ADDRESS_WIDTH-1:0] I_PC,
    output logic                       O_PC_ENABLE,
    output logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS,
    output logic                       O_PC_ADDRESS_SELECT,
    output logic                       O_PC_ADDRESS_SELECT_INCREMENT,
    output logic                       O_PC_ADDRESS_SELECT_DISPLACE,
    output logic                       O_MEM_RE,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    input  logic                       I_MEM_VALID,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
    input  logic [4:0]                 I_FLAGS,
    output logic [3:0]                 O_RTARGET_INDEX,
    input  logic [P_DATA_WIDTH-1:0]    I_RTARGET_DATA,
    output logic                       O_LINK_WE,
    output logic [3:0]                 O_LINK_INDEX,
    output logic [P_DATA_WIDTH-1:0]    O_LINK_DATA,
    output logic                       O_EXEC_START,
    output logic [P_DATA_WIDTH-1:0]    O_INSTRUCTION,
    input  logic                       I_EXEC_DONE,
    output logic [15:0]                O_TAKEN_COUNT
);

    state_t state, state_nxt;
    logic   is_bcond, is_jcond, is_jal, cond_taken, taken, mem_accept;

    assign is_bcond   = O_INSTRUCTION[15:12] == OP_BCOND;
    assign is_jcond   = O_INSTRUCTION[15:12] == OP_JEXT && O_INSTRUCTION[7:4] == EXT_JCOND;
    assign is_jal     = O_INSTRUCTION[15:12] == OP_JEXT && O_INSTRUCTION[7:4] == EXT_JAL;
    assign taken      = is_jal || ((is_bcond || is_jcond) && cond_taken);
    assign mem_accept = state == S_WAIT && I_MEM_VALID;

    assign O_PC_ADDRESS_SELECT_INCREMENT = 1'b0;

    cond_eval u_cond_eval (
        .I_COND  (O_INSTRUCTION[11:8]),
        .I_FLAGS (I_FLAGS),
        .O_TAKEN (cond_taken)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) state <= S_FETCH;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = I_MEM_VALID ? S_DECODE : S_WAIT;
            S_DECODE: state_nxt = is_ctrl(O_INSTRUCTION[15:0]) ? S_UPDATE : S_EXEC;
            S_EXEC:   state_nxt = I_EXEC_DONE ? S_UPDATE : S_EXEC;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Start is launched while entering DECODE so a same-cycle done is never seen in EXEC.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            O_PC_ENABLE                  <= 1'b0;
            O_PC_ADDRESS                 <= '0;
            O_PC_ADDRESS_SELECT          <= 1'b0;
            O_PC_ADDRESS_SELECT_DISPLACE <= 1'b0;
            O_MEM_RE                     <= 1'b0;
            O_MEM_ADDRESS                <= '0;
            O_RTARGET_INDEX              <= '0;
            O_LINK_WE                    <= 1'b0;
            O_LINK_INDEX                 <= '0;
            O_LINK_DATA                  <= '0;
            O_EXEC_START                 <= 1'b0;
            O_INSTRUCTION                <= '0;
        end else begin
            O_MEM_RE     <= state_nxt == S_WAIT;
            O_PC_ENABLE  <= state != S_UPDATE && state_nxt == S_UPDATE;
            O_EXEC_START <= mem_accept && !is_ctrl(I_MEM_DATA[15:0]);
            if (state == S_FETCH) O_MEM_ADDRESS <= I_PC;
            if (mem_accept) begin
                O_INSTRUCTION   <= I_MEM_DATA;
                O_RTARGET_INDEX <= I_MEM_DATA[3:0];
            end
            if (state == S_DECODE) begin
                O_PC_ADDRESS_SELECT          <= taken;
                O_PC_ADDRESS_SELECT_DISPLACE <= is_bcond && cond_taken;
                O_PC_ADDRESS                 <= is_bcond ? P_ADDRESS_WIDTH'($signed(O_INSTRUCTION[7:0]))
                                                         : P_ADDRESS_WIDTH'(I_RTARGET_DATA);
                O_LINK_WE                    <= is_jal;
                O_LINK_INDEX                 <= O_INSTRUCTION[11:8];
                O_LINK_DATA                  <= P_DATA_WIDTH'(I_PC + 1'b1);
            end else if (state == S_UPDATE) begin
                O_PC_ADDRESS_SELECT          <= 1'b0;
                O_PC_ADDRESS_SELECT_DISPLACE <= 1'b0;
                O_LINK_WE                    <= 1'b0;
            end
        end
    end

`ifdef PC_CTRL_TAKEN_COUNT_EN
    logic [15:0] taken_cnt;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET)
            taken_cnt <= '0;
        else if (state == S_UPDATE && O_PC_ADDRESS_SELECT && taken_cnt != 16'hFFFF)
            taken_cnt <= taken_cnt + 16'd1;
    end

    assign O_TAKEN_COUNT = taken_cnt;
`else
    assign O_TAKEN_COUNT = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed-vector bench for pc_ctrl with hand-computed expectations.
module tb_pc_ctrl;

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b0;
    logic [15:0] I_PC = '0;
    logic        O_PC_ENABLE;
    logic [15:0] O_PC_ADDRESS;
    logic        O_PC_ADDRESS_SELECT;
    logic        O_PC_ADDRESS_SELECT_INCREMENT;
    logic        O_PC_ADDRESS_SELECT_DISPLACE;
    logic        O_MEM_RE;
    logic [15:0] O_MEM_ADDRESS;
    logic        I_MEM_VALID = 1'b0;
    logic [15:0] I_MEM_DATA = '0;
    logic [4:0]  I_FLAGS = '0;
    logic [3:0]  O_RTARGET_INDEX;
    logic [15:0] I_RTARGET_DATA;
    logic        O_LINK_WE;
    logic [3:0]  O_LINK_INDEX;
    logic [15:0] O_LINK_DATA;
    logic        O_EXEC_START;
    logic [15:0] O_INSTRUCTION;
    logic        I_EXEC_DONE = 1'b0;
    logic [15:0] O_TAKEN_COUNT;

    logic [15:0] regs [16];
    int          vectors = 0;
    int          miscompares = 0;

    assign I_RTARGET_DATA = regs[O_RTARGET_INDEX];

    always #5 I_CLK = ~I_CLK;

    pc_ctrl #(.P_ADDRESS_WIDTH(16), .P_DATA_WIDTH(16)) dut (
        .I_CLK                         (I_CLK),
        .I_NRESET                      (I_NRESET),
        .I_PC                          (I_PC),
        .O_PC_ENABLE                   (O_PC_ENABLE),
        .O_PC_ADDRESS                  (O_PC_ADDRESS),
        .O_PC_ADDRESS_SELECT           (O_PC_ADDRESS_SELECT),
        .O_PC_ADDRESS_SELECT_INCREMENT (O_PC_ADDRESS_SELECT_INCREMENT),
        .O_PC_ADDRESS_SELECT_DISPLACE  (O_PC_ADDRESS_SELECT_DISPLACE),
        .O_MEM_RE                      (O_MEM_RE),
        .O_MEM_ADDRESS                 (O_MEM_ADDRESS),
        .I_MEM_VALID                   (I_MEM_VALID),
        .I_MEM_DATA                    (I_MEM_DATA),
        .I_FLAGS                       (I_FLAGS),
        .O_RTARGET_INDEX               (O_RTARGET_INDEX),
        .I_RTARGET_DATA                (I_RTARGET_DATA),
        .O_LINK_WE                     (O_LINK_WE),
        .O_LINK_INDEX                  (O_LINK_INDEX),
        .O_LINK_DATA                   (O_LINK_DATA),
        .O_EXEC_START                  (O_EXEC_START),
        .O_INSTRUCTION                 (O_INSTRUCTION),
        .I_EXEC_DONE                   (I_EXEC_DONE),
        .O_TAKEN_COUNT                 (O_TAKEN_COUNT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge of the DECODE cycle.
    task automatic fetch(input string tag, input logic [15:0] ins, input logic [15:0] pc, input int gap);
        int n = 0;
        while (!O_MEM_RE && n < 20) begin
            @(negedge I_CLK);
            n++;
        end
        check({tag, "_re"}, O_MEM_RE, 1);
        check({tag, "_addr"}, O_MEM_ADDRESS, pc);
        repeat (gap) @(negedge I_CLK);
        I_MEM_VALID = 1'b1;
        I_MEM_DATA  = ins;
        @(negedge I_CLK);
        I_MEM_VALID = 1'b0;
        check({tag, "_instr"}, O_INSTRUCTION, ins);
    endtask

    task automatic expect_update(input string tag, input logic sel, input logic disp,
                                 input logic [15:0] addr, input logic lwe,
                                 input logic [3:0] lidx, input logic [15:0] ldata);
        int n = 0;
        while (!O_PC_ENABLE && n < 20) begin
            @(negedge I_CLK);
            n++;
        end
        check({tag, "_en"}, O_PC_ENABLE, 1);
        check({tag, "_sel"}, O_PC_ADDRESS_SELECT, sel);
        check({tag, "_disp"}, O_PC_ADDRESS_SELECT_DISPLACE, disp);
        check({tag, "_inc"}, O_PC_ADDRESS_SELECT_INCREMENT, 0);
        check({tag, "_lwe"}, O_LINK_WE, lwe);
        if (sel) check({tag, "_paddr"}, O_PC_ADDRESS, addr);
        if (lwe) begin
            check({tag, "_lidx"}, O_LINK_INDEX, lidx);
            check({tag, "_ldata"}, O_LINK_DATA, ldata);
        end
        @(negedge I_CLK);
        check({tag, "_en_fall"}, O_PC_ENABLE, 0);
        check({tag, "_lwe_fall"}, O_LINK_WE, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        regs[5] = 16'h0123;
        regs[3] = 16'h0200;
        #1;
        check("rst_en", O_PC_ENABLE, 0);
        check("rst_re", O_MEM_RE, 0);
        check("rst_start", O_EXEC_START, 0);
        check("rst_instr", O_INSTRUCTION, 0);
        check("rst_count", O_TAKEN_COUNT, 0);
        repeat (2) @(negedge I_CLK);
        I_NRESET = 1'b1;

        // ALU op; done raised alongside start must not shortcut EXEC
        fetch("alu", 16'h0000, 16'h0000, 1);
        check("alu_start", O_EXEC_START, 1);
        I_EXEC_DONE = 1'b1;
        @(negedge I_CLK);
        I_EXEC_DONE = 1'b0;
        check("alu_start_pulse", O_EXEC_START, 0);
        check("alu_early_en", O_PC_ENABLE, 0);
        @(negedge I_CLK);
        check("alu_wait_en", O_PC_ENABLE, 0);
        I_EXEC_DONE = 1'b1;
        @(negedge I_CLK);
        I_EXEC_DONE = 1'b0;
        expect_update("alu", 0, 0, 16'h0000, 0, 4'h0, 16'h0000);

        I_PC = 16'h0010;
        I_FLAGS = 5'b01000;
        fetch("beq_t", 16'hC0FD, 16'h0010, 0);
        check("beq_t_start", O_EXEC_START, 0);
        expect_update("beq_t", 1, 1, 16'hFFFD, 0, 4'h0, 16'h0000);

        I_FLAGS = 5'b00000;
        fetch("beq_nt", 16'hC0FD, 16'h0010, 0);
        expect_update("beq_nt", 0, 0, 16'h0000, 0, 4'h0, 16'h0000);

        fetch("juc", 16'h4EC5, 16'h0010, 0);
        check("juc_ridx", O_RTARGET_INDEX, 5);
        expect_update("juc", 1, 0, 16'h0123, 0, 4'h0, 16'h0000);

        I_PC = 16'h0040;
        fetch("jal", 16'h4E83, 16'h0040, 0);
        expect_update("jal", 1, 0, 16'h0200, 1, 4'hE, 16'h0041);
`ifdef PC_CTRL_TAKEN_COUNT_EN
        check("taken_count", O_TAKEN_COUNT, 3);
`else
        check("taken_count", O_TAKEN_COUNT, 0);
`endif

        I_FLAGS = 5'b00000;
        fetch("blt_t", 16'hCC05, 16'h0040, 0);
        expect_update("blt_t", 1, 1, 16'h0005, 0, 4'h0, 16'h0000);
        I_FLAGS = 5'b10000;
        fetch("blt_nt", 16'hCC05, 16'h0040, 0);
        expect_update("blt_nt", 0, 0, 16'h0000, 0, 4'h0, 16'h0000);
        I_FLAGS = 5'b11111;
        fetch("bnv", 16'hCF10, 16'h0040, 0);
        expect_update("bnv", 0, 0, 16'h0000, 0, 4'h0, 16'h0000);

        // reset while the datapath is busy
        fetch("mid", 16'h1234, 16'h0040, 0);
        check("mid_start", O_EXEC_START, 1);
        @(negedge I_CLK);
        I_NRESET = 1'b0;
        #1;
        check("mid_rst_en", O_PC_ENABLE, 0);
        check("mid_rst_re", O_MEM_RE, 0);
        check("mid_rst_start", O_EXEC_START, 0);
        check("mid_rst_instr", O_INSTRUCTION, 0);
        check("mid_rst_sel", O_PC_ADDRESS_SELECT, 0);
        check("mid_rst_maddr", O_MEM_ADDRESS, 0);
        check("mid_rst_count", O_TAKEN_COUNT, 0);
        I_EXEC_DONE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge I_CLK);
            check("mid_rst_no_en", O_PC_ENABLE, 0);
        end
        I_EXEC_DONE = 1'b0;
        I_PC = 16'h0077;
        I_NRESET = 1'b1;
        @(negedge I_CLK);
        check("restart_no_en", O_PC_ENABLE, 0);
        fetch("restart", 16'h4EC5, 16'h0077, 0);
        expect_update("restart", 1, 0, 16'h0123, 0, 4'h0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
